// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer: load/start/pause requests in,
// registered count/busy/tc out.
interface down_counter_timer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;

  // Controller side: drives requests, observes the timer.
  modport master (
    output load, load_val, start, pause,
    input  count, busy, tc
  );

  // Timer side.
  modport slave (
    input  load, load_val, start, pause,
    output count, busy, tc
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable WIDTH-bit countdown timer with start/pause control and a one-cycle
// terminal-count pulse.
// Optional feature: define AUTO_RELOAD_EN to reload the last loaded value at
// terminal count and keep running (periodic tc). Default build stops in IDLE.
module down_counter_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  down_counter_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic             busy_q;
  logic             tc_q;
`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_reg;
`endif

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.tc    = tc_q;

  // Timer FSM: priority reset > load > pause > start/decrement; tc defaults low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_reg <= '0;
`endif
    end else begin
      tc_q <= 1'b0;
      if (bus.load) begin
        // Load aborts any run in progress; a same-cycle start is dropped.
        count_q <= bus.load_val;
        state   <= IDLE;
        busy_q  <= 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_reg <= bus.load_val;
`endif
      end else begin
        case (state)
          IDLE: begin
            // Starting from zero would give no meaningful countdown.
            if (bus.start && (count_q != '0)) begin
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end
          RUN: begin
            if (bus.pause) begin
              state <= PAUSE;
            end else if (count_q == WIDTH'(1)) begin
              tc_q <= 1'b1;
`ifdef AUTO_RELOAD_EN
              count_q <= reload_reg;
`else
              count_q <= '0;
              state   <= IDLE;
              busy_q  <= 1'b0;
`endif
            end else begin
              count_q <= count_q - WIDTH'(1);
            end
          end
          PAUSE: begin
            // Resume edge only changes state; decrement continues next edge.
            if (!bus.pause) begin
              state <= RUN;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: table of per-edge vectors plus
// hand-written sequences for reset, boundary and auto-reload behaviour.
module tb_down_counter_timer;

  localparam int unsigned W = 8;
`ifdef AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         pause;
    logic [W-1:0] count;
    logic         busy;
    logic         tc;
    string        name;
  } vec_t;

  typedef struct {
    logic [W-1:0] count;
    logic         busy;
    logic         tc;
    string        name;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  vec_t tbl[$];
  exp_t sb[$];

  down_counter_timer_if #(.WIDTH(W)) bus ();

  down_counter_timer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic ld, input logic [W-1:0] lv,
                              input logic st, input logic ps,
                              input logic [W-1:0] ec, input logic eb,
                              input logic et, input string nm);
    vec_t v;
    v.load = ld; v.load_val = lv; v.start = st; v.pause = ps;
    v.count = ec; v.busy = eb; v.tc = et; v.name = nm;
    tbl.push_back(v);
  endfunction

  task automatic check(input exp_t e);
    n_tests++;
    if ({bus.count, bus.busy, bus.tc} !== {e.count, e.busy, e.tc}) begin
      n_fail++;
      $display("FAIL %s: got count=%0d busy=%0b tc=%0b, expected count=%0d busy=%0b tc=%0b",
               e.name, bus.count, bus.busy, bus.tc, e.count, e.busy, e.tc);
    end
  endtask

  // Drive one edge's inputs, queue the expectation, compare after the edge.
  task automatic step(input logic ld, input logic [W-1:0] lv,
                      input logic st, input logic ps,
                      input logic [W-1:0] ec, input logic eb,
                      input logic et, input string nm);
    exp_t e;
    @(negedge clk);
    bus.load = ld; bus.load_val = lv; bus.start = st; bus.pause = ps;
    e.count = ec; e.busy = eb; e.tc = et; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, expected an entry", nm);
    end else begin
      check(sb.pop_front());
    end
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ec;
    n_tests = 0;
    n_fail  = 0;
    bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0; bus.pause = 1'b0;
    reset = 1'b1;

    // Basic countdown from 3
    add(1, 8'd3, 0, 0, 8'd3, 0, 0, "load3");
    add(0, 8'd0, 1, 0, 8'd3, 1, 0, "start3_hold");
    add(0, 8'd0, 0, 0, 8'd2, 1, 0, "dec_2");
    add(0, 8'd0, 0, 0, 8'd1, 1, 0, "dec_1");
    add(0, 8'd0, 0, 0, AR ? 8'd3 : 8'd0, AR, 1, "terminal_tc");
    add(0, 8'd0, 0, 0, AR ? 8'd2 : 8'd0, AR, 0, "after_terminal");
    // Load and start on the same edge: start dropped
    add(1, 8'd7, 1, 0, 8'd7, 0, 0, "load_start_same");
    add(0, 8'd0, 0, 0, 8'd7, 0, 0, "still_idle");
    // Start with count zero
    add(1, 8'd0, 0, 0, 8'd0, 0, 0, "load0");
    add(0, 8'd0, 1, 0, 8'd0, 0, 0, "start_zero");
    add(0, 8'd0, 0, 0, 8'd0, 0, 0, "start_zero_idle");
    // Pause for four cycles after the first decrement
    add(1, 8'd5, 0, 0, 8'd5, 0, 0, "load5");
    add(0, 8'd0, 1, 0, 8'd5, 1, 0, "start5");
    add(0, 8'd0, 0, 0, 8'd4, 1, 0, "dec_4");
    add(0, 8'd0, 0, 1, 8'd4, 1, 0, "pause_1");
    add(0, 8'd0, 1, 1, 8'd4, 1, 0, "pause_2_start_ign");
    add(0, 8'd0, 0, 1, 8'd4, 1, 0, "pause_3");
    add(0, 8'd0, 0, 1, 8'd4, 1, 0, "pause_4");
    add(0, 8'd0, 0, 0, 8'd4, 1, 0, "resume_hold");
    add(0, 8'd0, 0, 0, 8'd3, 1, 0, "resume_dec_3");
    add(0, 8'd0, 1, 0, 8'd2, 1, 0, "run_start_ign");
    add(0, 8'd0, 0, 0, 8'd1, 1, 0, "resume_dec_1");
    add(0, 8'd0, 0, 0, AR ? 8'd5 : 8'd0, AR, 1, "pause_seq_tc");
    // Pause on the terminal edge holds at 1
    add(1, 8'd2, 0, 0, 8'd2, 0, 0, "load2");
    add(0, 8'd0, 1, 0, 8'd2, 1, 0, "start2");
    add(0, 8'd0, 0, 0, 8'd1, 1, 0, "dec_to_1");
    add(0, 8'd0, 0, 1, 8'd1, 1, 0, "pause_at_1");
    add(0, 8'd0, 0, 1, 8'd1, 1, 0, "pause_at_1_hold");
    add(0, 8'd0, 0, 0, 8'd1, 1, 0, "resume_at_1");
    add(0, 8'd0, 0, 0, AR ? 8'd2 : 8'd0, AR, 1, "late_tc");
    // Load aborts a paused run
    add(1, 8'd6, 0, 0, 8'd6, 0, 0, "load6");
    add(0, 8'd0, 1, 0, 8'd6, 1, 0, "start6");
    add(0, 8'd0, 0, 1, 8'd6, 1, 0, "pause6");
    add(1, 8'd9, 0, 1, 8'd9, 0, 0, "load_in_pause");
    add(0, 8'd0, 0, 1, 8'd9, 0, 0, "idle_after_abort");

    // Reset state
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    e.count = '0; e.busy = 1'b0; e.tc = 1'b0; e.name = "reset_state";
    check(e);

    foreach (tbl[i])
      step(tbl[i].load, tbl[i].load_val, tbl[i].start, tbl[i].pause,
           tbl[i].count, tbl[i].busy, tbl[i].tc, tbl[i].name);

    // Asynchronous reset in the middle of a run
    step(1, 8'd9, 0, 0, 8'd9, 0, 0, "rst_load9");
    step(0, 8'd0, 1, 0, 8'd9, 1, 0, "rst_start9");
    step(0, 8'd0, 0, 0, 8'd8, 1, 0, "rst_dec_8");
    step(0, 8'd0, 0, 0, 8'd7, 1, 0, "rst_dec_7");
    step(0, 8'd0, 0, 0, 8'd6, 1, 0, "rst_dec_6");
    #2 reset = 1'b1;
    #1;
    e.count = '0; e.busy = 1'b0; e.tc = 1'b0; e.name = "async_reset";
    check(e);
    @(negedge clk);
    reset = 1'b0;
    step(0, 8'd0, 0, 0, 8'd0, 0, 0, "post_reset_idle");

    // Boundary: full-range countdown from 255, no wrap
    step(1, 8'hFF, 0, 0, 8'hFF, 0, 0, "load_ff");
    step(0, 8'd0, 1, 0, 8'hFF, 1, 0, "start_ff");
    for (int i = 1; i <= 255; i++) begin
      if (i == 255) step(0, 8'd0, 0, 0, AR ? 8'hFF : 8'd0, AR, 1, "ff_terminal");
      else          step(0, 8'd0, 0, 0, 8'(255 - i), 1, 0, "ff_count");
    end
    step(0, 8'd0, 0, 0, AR ? 8'hFE : 8'd0, AR, 0, "ff_no_wrap");
    step(0, 8'd0, 0, 0, AR ? 8'hFD : 8'd0, AR, 0, "ff_no_wrap2");

`ifdef AUTO_RELOAD_EN
    // Periodic tc every 4 cycles
    step(1, 8'd4, 0, 0, 8'd4, 0, 0, "ar_load4");
    step(0, 8'd0, 1, 0, 8'd4, 1, 0, "ar_start4");
    for (int i = 1; i <= 12; i++) begin
      ec = (i % 4 == 0) ? 8'd4 : 8'(4 - (i % 4));
      step(0, 8'd0, 0, 0, ec, 1, (i % 4 == 0), "ar_periodic");
    end
    step(1, 8'd0, 0, 0, 8'd0, 0, 0, "ar_load0");
    step(0, 8'd0, 1, 0, 8'd0, 0, 0, "ar_start_zero");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
